// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache miss interfaces.
// One transaction in flight, round-robin on ties, and cancelled I-cache refills are absorbed.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_addr_send,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_cancel,
  output logic              ic_addr_ok,
  output logic              ic_data_ok,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_addr_send,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_we,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_addr_ok,
  output logic              dc_data_ok,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              mem_owner
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic OwnIc = 1'b0;
  localparam logic OwnDc = 1'b1;

  state_e            state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;
  logic              cancel_pending_q;
  logic              last_grant_q;

  logic grant_dc;
  logic ic_owns;
  logic ic_cancel_hit;

  // On a tie the requester that did not win last time goes first.
  assign grant_dc = dc_addr_send && (!ic_addr_send || (last_grant_q == OwnIc));

  assign ic_owns       = (owner_q == OwnIc);
  assign ic_cancel_hit = ic_owns && ic_cancel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      owner_q          <= OwnIc;
      addr_q           <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      cancel_pending_q <= 1'b0;
      last_grant_q     <= OwnDc;
    end else begin
      case (state_q)
        StIdle: begin
          if (ic_addr_send || dc_addr_send) begin
            owner_q <= grant_dc;
            addr_q  <= grant_dc ? dc_addr : ic_addr;
            we_q    <= grant_dc & dc_we;
            wdata_q <= grant_dc ? dc_wdata : '0;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (ic_cancel_hit) cancel_pending_q <= 1'b1;
          if (mem_addr_ok) begin
            last_grant_q <= owner_q;
            state_q      <= StData;
          end
        end
        StData: begin
          if (mem_data_ok) begin
            cancel_pending_q <= 1'b0;
            state_q          <= StIdle;
          end else if (ic_cancel_hit) begin
            cancel_pending_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req   = (state_q == StAddr);
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_owner = owner_q;

  assign ic_addr_ok = (state_q == StAddr) && mem_addr_ok && ic_owns;
  assign dc_addr_ok = (state_q == StAddr) && mem_addr_ok && !ic_owns;

  // A cancel landing on the completion cycle suppresses the pulse just like a pending one.
  assign ic_data_ok = (state_q == StData) && mem_data_ok && ic_owns &&
                      !cancel_pending_q && !ic_cancel;
  assign dc_data_ok = (state_q == StData) && mem_data_ok && !ic_owns;

  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Transaction-level self-checking bench for cache_mem_arbiter with randomized traffic.
module tb_cache_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_addr_send, ic_cancel, ic_addr_ok, ic_data_ok;
  logic [AW-1:0] ic_addr;
  logic [LW-1:0] ic_rdata;
  logic          dc_addr_send, dc_we, dc_addr_ok, dc_data_ok;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata, dc_rdata;
  logic          mem_req, mem_we, mem_addr_ok, mem_data_ok, mem_owner;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  bit m_last = 1'b1;  // model of who won the last accepted address (1 = D-cache)

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ic_addr_send (ic_addr_send),
    .ic_addr      (ic_addr),
    .ic_cancel    (ic_cancel),
    .ic_addr_ok   (ic_addr_ok),
    .ic_data_ok   (ic_data_ok),
    .ic_rdata     (ic_rdata),
    .dc_addr_send (dc_addr_send),
    .dc_addr      (dc_addr),
    .dc_we        (dc_we),
    .dc_wdata     (dc_wdata),
    .dc_addr_ok   (dc_addr_ok),
    .dc_data_ok   (dc_data_ok),
    .dc_rdata     (dc_rdata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .mem_owner    (mem_owner)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue_ic(input logic [AW-1:0] a);
    ic_addr_send = 1'b1;
    ic_addr      = a;
  endtask

  task automatic issue_dc(input logic [AW-1:0] a, input logic we, input logic [LW-1:0] wd);
    dc_addr_send = 1'b1;
    dc_addr      = a;
    dc_we        = we;
    dc_wdata     = wd;
  endtask

  // Runs one whole transaction starting from an IDLE cycle. ADDR lasts a_lat+1 cycles, DATA
  // d_lat+1 cycles. cancel_at indexes the ADDR/DATA cycles; -2 pulses cancel in IDLE, -1 never.
  task automatic do_txn(input int a_lat, input int d_lat, input int cancel_at,
                        input logic [LW-1:0] rd);
    bit            own, last, canc, exp_ic, exp_dc;
    logic [AW-1:0] ea;
    bit            ewe;
    logic [LW-1:0] ewd, r;
    int            c;
    own = (ic_addr_send && dc_addr_send) ? !m_last : dc_addr_send;
    ea  = own ? dc_addr : ic_addr;
    ewe = own ? dc_we : 1'b0;
    ewd = own ? dc_wdata : '0;
    ic_cancel   = (cancel_at == -2);
    mem_addr_ok = 1'($urandom);
    mem_data_ok = 1'($urandom);
    #1;
    total++;
    if (mem_req !== 1'b0 || ic_addr_ok !== 1'b0 || dc_addr_ok !== 1'b0 ||
        ic_data_ok !== 1'b0 || dc_data_ok !== 1'b0) begin
      bad++;
      $display("FAIL idle_outputs: req=%b iao=%b dao=%b ido=%b ddo=%b, want all 0",
               mem_req, ic_addr_ok, dc_addr_ok, ic_data_ok, dc_data_ok);
    end
    next_cycle();
    c = 0;
    for (int i = 0; i <= a_lat; i++) begin
      last        = (i == a_lat);
      ic_cancel   = (c == cancel_at);
      mem_addr_ok = last;
      mem_data_ok = 1'($urandom);
      mem_rdata   = rnd_line();
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== ea || mem_we !== ewe || mem_wdata !== ewd ||
          mem_owner !== own) begin
        bad++;
        $display("FAIL addr_phase: req=%b addr=%h we=%b own=%b wd=%h, want 1 %h %b %b %h",
                 mem_req, mem_addr, mem_we, mem_owner, mem_wdata, ea, ewe, own, ewd);
      end
      total++;
      if (ic_addr_ok !== (last && !own) || dc_addr_ok !== (last && own) ||
          ic_data_ok !== 1'b0 || dc_data_ok !== 1'b0) begin
        bad++;
        $display("FAIL addr_ok: iao=%b dao=%b ido=%b ddo=%b, want %b %b 0 0",
                 ic_addr_ok, dc_addr_ok, ic_data_ok, dc_data_ok, last && !own, last && own);
      end
      next_cycle();
      c++;
    end
    m_last = own;
    if (own) dc_addr_send = 1'b0;
    else     ic_addr_send = 1'b0;
    for (int j = 0; j <= d_lat; j++) begin
      last        = (j == d_lat);
      ic_cancel   = (c == cancel_at);
      mem_data_ok = last;
      mem_addr_ok = 1'($urandom);
      r           = last ? rd : rnd_line();
      mem_rdata   = r;
      canc        = (cancel_at >= 0) && (cancel_at <= c);
      exp_ic      = last && !own && !canc;
      exp_dc      = last && own;
      #1;
      total++;
      if (mem_req !== 1'b0 || ic_addr_ok !== 1'b0 || dc_addr_ok !== 1'b0) begin
        bad++;
        $display("FAIL data_phase: req=%b iao=%b dao=%b, want 0 0 0",
                 mem_req, ic_addr_ok, dc_addr_ok);
      end
      total++;
      if (ic_data_ok !== exp_ic || dc_data_ok !== exp_dc) begin
        bad++;
        $display("FAIL data_ok: ido=%b ddo=%b, want %b %b (own=%b cancel_at=%0d c=%0d)",
                 ic_data_ok, dc_data_ok, exp_ic, exp_dc, own, cancel_at, c);
      end
      total++;
      if (ic_rdata !== r || dc_rdata !== r) begin
        bad++;
        $display("FAIL rdata: ic=%h dc=%h, want %h", ic_rdata, dc_rdata, r);
      end
      next_cycle();
      c++;
    end
    ic_cancel   = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        mem_owner !== 1'b0 || ic_addr_ok !== 1'b0 || dc_addr_ok !== 1'b0 ||
        ic_data_ok !== 1'b0 || dc_data_ok !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: req=%b we=%b addr=%h own=%b oks=%b%b%b%b, want all 0",
               mem_req, mem_we, mem_addr, mem_owner, ic_addr_ok, dc_addr_ok,
               ic_data_ok, dc_data_ok);
    end
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    m_last      = 1'b1;
  endtask

  task automatic test_tie();
    issue_ic(32'h0000_2000);
    issue_dc(32'h0000_3000, 1'b0, rnd_line());
    do_txn(0, 0, -1, rnd_line());
    do_txn(1, 1, -1, rnd_line());
    issue_ic(32'h0000_2040);
    issue_dc(32'h0000_3040, 1'b0, rnd_line());
    do_txn(0, 1, -1, rnd_line());
    do_txn(0, 0, -1, rnd_line());
  endtask

  task automatic test_ic_only();
    issue_ic(32'h0000_1000);
    do_txn(1, 2, -1, {16{8'hA5}});
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL ic_only_idle: req=%b, want 0", mem_req);
    end
  endtask

  task automatic test_dc_writeback();
    issue_dc(32'h8000_0040, 1'b1, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
    do_txn(2, 1, -1, rnd_line());
  endtask

  task automatic test_cancel_data();
    issue_ic(32'h0000_4000);
    issue_dc(32'h0000_5000, 1'b0, rnd_line());
    do_txn(1, 2, 2, rnd_line());  // cycle 2 is the first DATA cycle
    do_txn(0, 0, -1, rnd_line());
  endtask

  task automatic test_cancel_coincident();
    issue_ic(32'h0000_6000);
    do_txn(0, 2, 3, rnd_line());
    issue_ic(32'h0000_6040);
    do_txn(1, 0, -2, rnd_line());
  endtask

  task automatic test_cancel_dc_owner();
    issue_dc(32'h0000_7000, 1'b0, rnd_line());
    do_txn(1, 1, 0, rnd_line());
    issue_dc(32'h0000_7040, 1'b1, rnd_line());
    do_txn(0, 2, 2, rnd_line());
    issue_ic(32'h0000_7080);
    do_txn(0, 0, -1, rnd_line());
  endtask

  task automatic test_reset_mid();
    issue_ic(32'h0000_9000);
    next_cycle();
    mem_addr_ok = 1'b1;
    next_cycle();
    mem_addr_ok  = 1'b0;
    ic_addr_send = 1'b0;
    reset        = 1'b1;
    next_cycle();
    reset       = 1'b0;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || ic_addr_ok !== 1'b0 || dc_addr_ok !== 1'b0 ||
        ic_data_ok !== 1'b0 || dc_data_ok !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: req=%b addr=%h oks=%b%b%b%b, want 0 0 0000",
               mem_req, mem_addr, ic_addr_ok, dc_addr_ok, ic_data_ok, dc_data_ok);
    end
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    m_last      = 1'b1;
    issue_ic(32'h0000_9100);
    issue_dc(32'h0000_9200, 1'b1, rnd_line());
    do_txn(0, 0, -1, rnd_line());
    do_txn(0, 0, -1, rnd_line());
  endtask

  task automatic test_random();
    int a, d;
    for (int n = 0; n < 80; n++) begin
      if (!ic_addr_send && ($urandom_range(0, 1) == 1)) issue_ic($urandom);
      if (!dc_addr_send && ($urandom_range(0, 1) == 1))
        issue_dc($urandom, 1'($urandom), rnd_line());
      if (!ic_addr_send && !dc_addr_send) issue_ic($urandom);
      a = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 3));
      do_txn(a, d, int'($urandom_range(0, a + d + 4)) - 2, rnd_line());
    end
    while (ic_addr_send || dc_addr_send) do_txn(0, 0, -1, rnd_line());
  endtask

  initial begin
    reset        = 1'b1;
    ic_addr_send = 1'b0;
    ic_addr      = '0;
    ic_cancel    = 1'b0;
    dc_addr_send = 1'b0;
    dc_addr      = '0;
    dc_we        = 1'b0;
    dc_wdata     = '0;
    mem_addr_ok  = 1'b0;
    mem_data_ok  = 1'b0;
    mem_rdata    = '0;
    test_reset();
    test_tie();
    test_ic_only();
    test_dc_writeback();
    test_cancel_data();
    test_cancel_coincident();
    test_cancel_dc_owner();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single line-wide memory port between the I-cache miss/refill interface and the D-cache miss/writeback interface. Each cache drives the same handshake toward memory: hold `addr_send` until `addr_ok`, then wait for `data_ok`. The arbiter serialises these requests with one transaction outstanding, and uses round-robin on simultaneous requests. It also absorbs I-cache refills cancelled by a front-end redirect, so stale lines never reach the cache.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 128, memory data width (one refill beat)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ic_addr_send  in  1  I-cache request; held until ic_addr_ok
- ic_addr  in  ADDR_W  I-cache miss address
- ic_cancel  in  1  single-cycle pulse; discard the I-cache's in-flight refill
- ic_addr_ok  out  1  I-cache address accepted (1-cycle pulse)
- ic_data_ok  out  1  I-cache refill data valid on ic_rdata (1-cycle pulse)
- ic_rdata  out  LINE_W  wired to mem_rdata
- dc_addr_send  in  1  D-cache request; held until dc_addr_ok
- dc_addr  in  ADDR_W  D-cache address
- dc_we  in  1  1 = writeback, 0 = refill
- dc_wdata  in  LINE_W  writeback data
- dc_addr_ok  out  1  D-cache address accepted (1-cycle pulse)
- dc_data_ok  out  1  D-cache read data valid / write complete (1-cycle pulse)
- dc_rdata  out  LINE_W  wired to mem_rdata
- mem_req  out  1  request valid toward memory
- mem_addr  out  ADDR_W  latched address
- mem_we  out  1  latched write flag
- mem_wdata  out  LINE_W  latched write data
- mem_addr_ok  in  1  memory accepted the address
- mem_data_ok  in  1  memory returns data or acknowledges the write
- mem_rdata  in  LINE_W  memory read data
- mem_owner  out  1  0 = I-cache, 1 = D-cache; valid outside IDLE

## Operation
- States are IDLE, ADDR and DATA. State, owner, address, we, wdata and cancel_pending are registered.
- IDLE:
  - One requester asserting: grant it.
  - Both asserting: grant the one that is not `last_grant`.
  - On a grant, latch `owner`, addr, we and wdata (wdata = 0 and we = 0 for the I-cache), then go to ADDR.
- ADDR:
  - mem_req = 1; mem_addr/we/wdata come from the latches.
  - When mem_addr_ok = 1: pulse the owner's addr_ok in the same cycle, set last_grant = owner, go to DATA.
- DATA:
  - mem_req = 0.
  - When mem_data_ok = 1: pulse the owner's data_ok in the same cycle, unless owner = I-cache and cancel_pending = 1. In that case no pulse is given and cancel_pending clears.
  - Either way, go to IDLE.
- ic_cancel:
  - Sets cancel_pending when asserted in ADDR or DATA with owner = I-cache.
  - The memory transaction always completes; it is never withdrawn.
  - Ignored in IDLE and while the D-cache owns the port.
  - ic_cancel in the same cycle as a DATA completion suppresses that cycle's ic_data_ok.
- A request pending at grant time in IDLE is latched even if ic_cancel is pulsed in the same cycle. The I-cache must deassert addr_send itself.
- Requester inputs are not sampled after the grant. Changing or dropping addr_send before addr_ok is a protocol violation; the latched transaction proceeds.
- ic_rdata and dc_rdata are always wired to mem_rdata. They are qualified only by the respective data_ok.
- addr_ok and data_ok are never asserted to the non-owner.

## Timing
- Reset values:
  - state = IDLE, last_grant = D-cache (the I-cache wins the first tie), cancel_pending = 0.
  - Outputs: mem_req, mem_we, all *_ok = 0; mem_addr and mem_wdata = 0; mem_owner = 0.
- Reset mid-transaction returns to IDLE next cycle with no ok pulses. The memory side is reset by the same signal.
- Arbitration latency is 1 cycle: a request seen in IDLE at cycle N gives mem_req = 1 at cycle N+1.
- Minimum transaction is 3 cycles: IDLE, then ADDR with mem_addr_ok, then DATA with mem_data_ok. The next grant is evaluated in the following IDLE cycle.
- addr_ok and data_ok are combinational from mem_addr_ok and mem_data_ok, gated by state and owner. They are never asserted for more than one cycle per transaction.
- mem_addr_ok in IDLE or DATA, and mem_data_ok in IDLE or ADDR, are ignored.

## Test plan
- I-cache only: ic_addr_send = 1, ic_addr = 0x0000_1000; memory answers addr_ok after 2 cycles and data_ok after 3 more with rdata = 0xA5..A5. Required: mem_req high for exactly 2 cycles with mem_addr = 0x1000, one ic_addr_ok pulse, then one ic_data_ok pulse with ic_rdata = 0xA5..A5, then IDLE.
- Tie after reset: both caches request in the same cycle. Required: I-cache granted first, D-cache second; a further tie grants the I-cache again (alternation).
- D-cache writeback: dc_we = 1, dc_addr = 0x8000_0040, dc_wdata = 0x1234... Required: mem_we = 1 and mem_wdata equal to the latched value throughout ADDR; dc_data_ok pulses on mem_data_ok; ic_* ok outputs stay 0.
- Cancel during DATA: pulse ic_cancel 1 cycle after ic_addr_ok. Required: the transaction completes, ic_data_ok stays 0, and the next queued D-cache request is granted in the following IDLE.
- Cancel coincident with mem_data_ok: ic_data_ok is suppressed. ic_cancel while the D-cache is owner: dc_data_ok still pulses and cancel_pending remains 0.
- Reset asserted in DATA: the next cycle is IDLE with mem_req = 0, no ok pulses and last_grant = D-cache.
